// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry banks of 2-bit saturating counters.
// A flush walks every entry clearing its valid bit, one entry per cycle, while fetch reports misses.
module branch_target_predictor #(
  parameter int DEPTH  = 256,
  parameter int TAG_W  = 8,
  parameter int HIST_W = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [31:0]       pc_f_i,
  input  logic [31:0]       pc_e_i,
  input  logic [31:0]       pc_target_e_i,
  input  logic              branch_e_i,
  input  logic              pc_src_res_e_i,
  input  logic              target_match_i,
  input  logic [HIST_W-1:0] local_src_i,
  input  logic              flush_i,
  output logic              hit_f_o,
  output logic              pc_src_pred_f_o,
  output logic [31:0]       pred_pc_target_f_o,
  output logic              busy_o
);

  localparam int INDEX_W = $clog2(DEPTH);
  localparam int NCTR    = 1 << HIST_W;
  localparam int CTR_W   = 2 * NCTR;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);

  logic              valid_q  [DEPTH];
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [31:0]       target_q [DEPTH];
  logic [CTR_W-1:0]  ctr_q    [DEPTH];

  logic [0:0]         state_q, state_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic               sweep_clr;

  logic [INDEX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0]   f_tag, e_tag;
  logic [HIST_W:0]    sel_base;
  logic [CTR_W-1:0]   f_entry, e_entry, e_entry_d;
  logic [1:0]         e_ctr;
  logic               e_hit, do_upd, alloc;
  logic               unused_pc_bits;

  assign f_idx    = pc_f_i[INDEX_W+1:2];
  assign f_tag    = pc_f_i[INDEX_W+TAG_W+1:INDEX_W+2];
  assign e_idx    = pc_e_i[INDEX_W+1:2];
  assign e_tag    = pc_e_i[INDEX_W+TAG_W+1:INDEX_W+2];
  assign sel_base = {local_src_i, 1'b0};
  assign unused_pc_bits = ^{pc_f_i, pc_e_i};

  assign busy_o             = (state_q == SWEEP);
  assign f_entry            = ctr_q[f_idx];
  assign hit_f_o            = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && !busy_o;
  assign pc_src_pred_f_o    = hit_f_o && f_entry[sel_base + 1'b1];
  assign pred_pc_target_f_o = hit_f_o ? target_q[f_idx] : 32'h0;

  assign e_entry = ctr_q[e_idx];
  assign e_ctr   = e_entry[sel_base +: 2];
  assign e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign do_upd  = branch_e_i && (state_q == IDLE);
  assign alloc   = !e_hit || !target_match_i;

  // A fresh allocation starts every history slot weakly not-taken before seeding the selected one.
  always_comb begin
    e_entry_d = e_entry;
    if (alloc) begin
      e_entry_d = {NCTR{2'b01}};
      e_entry_d[sel_base +: 2] = pc_src_res_e_i ? 2'b10 : 2'b00;
    end else if (pc_src_res_e_i) begin
      if (e_ctr != 2'b11) e_entry_d[sel_base +: 2] = e_ctr + 2'b01;
    end else begin
      if (e_ctr != 2'b00) e_entry_d[sel_base +: 2] = e_ctr - 2'b01;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sweep_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      default: begin
        sweep_clr = 1'b1;
        if (flush_i) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_IDX) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + INDEX_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= {NCTR{2'b01}};
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (sweep_clr) valid_q[ptr_q] <= 1'b0;
      if (do_upd) begin
        valid_q[e_idx] <= 1'b1;
        ctr_q[e_idx]   <= e_entry_d;
      end
    end
  end

  // Tags and targets carry no reset; they are only meaningful behind a set valid bit.
  always_ff @(posedge clk_i) begin
    if (do_upd && alloc) begin
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= pc_target_e_i;
    end
  end

endmodule
